game_flow_ctrl: RTL

Top-level game sequencer for the brick-breaker datapath. It owns the 3-bit game state that the paddle, ball and brick blocks decode. It gates paddle movement through paddle_en and sets paddle length per level. It also tracks lives and level, and issues one-cycle ball-reset and board-reload strobes.

---
 rtl/game_pkg.sv | 38 +++
 rtl/btn_edge.sv | 31 +++
 rtl/game_flow_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Constants shared by the brick-breaker blocks (game_flow_ctrl, paddle, ball,
// bricks):
//   - STATE_W and the 3-bit game state codes decoded by every datapath block
//   - SCREEN_W, the playfield width in pixels
//   - LEVEL_MAX, the level counter ceiling
//   - shrink_len(), the floored paddle-length reduction applied per level
// -----------------------------------------------------------------------------
package game_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE        = 3'b000;
    localparam logic [STATE_W-1:0] ST_SERVE       = 3'b001;
    localparam logic [STATE_W-1:0] ST_PLAY        = 3'b010;
    localparam logic [STATE_W-1:0] ST_LIFE_LOST   = 3'b011;
    localparam logic [STATE_W-1:0] ST_LEVEL_CLEAR = 3'b100;
    localparam logic [STATE_W-1:0] ST_GAME_OVER   = 3'b101;

    localparam int SCREEN_W = 160;

    localparam logic [2:0] LEVEL_MAX = 3'd7;

    // Returns max(min_len, len - step) without ever forming a negative value:
    // the comparison is done against min_len + step in a widened sum.
    function automatic logic [4:0] shrink_len(input logic [4:0] len,
                                              input logic [4:0] step,
                                              input logic [4:0] min_len);
        logic [5:0] floor_sum;
        floor_sum = {1'b0, min_len} + {1'b0, step};
        if ({1'b0, len} < floor_sum) begin
            return min_len;
        end
        return len - step;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// -----------------------------------------------------------------------------
// btn_edge
// Rising-edge detector for an already-synchronised key level.
// The history register resets to 1, so a key held down through reset release
// does not look like a fresh press.
// Ports:
//   clock   in  system clock
//   reset   in  synchronous, active-low
//   btn_i   in  key level
//   rise_o  out high in the cycle the key goes from low to high
// -----------------------------------------------------------------------------
module btn_edge (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= btn_i;
        end
    end

    assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
// Top-level game sequencer. Owns the game state decoded by the paddle, ball
// and brick blocks, tracks lives / level / paddle length, and issues the
// one-cycle ball_reset and board_reload strobes.
// Ports:
//   clock         in   system clock
//   reset         in   synchronous, active-low
//   frame_tick    in   one-cycle pulse per video frame (pause timer only)
//   start_btn     in   start key level
//   launch_btn    in   launch key level
//   ball_lost     in   pulse, ball fell below the paddle (PLAY only)
//   bricks_clear  in   level, no bricks left (PLAY only)
//   state         out  game state code (also the FSM debug view)
//   paddle_en     out  paddle may move (SERVE, PLAY)
//   paddle_len    out  current paddle length in pixels
//   lives         out  remaining lives
//   level         out  current level, saturating at 7
//   ball_reset    out  one-cycle strobe: park ball on paddle
//   board_reload  out  one-cycle strobe: reload brick field
//   game_over     out  high while in GAME_OVER
// -----------------------------------------------------------------------------
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned LEN_INIT     = 24,
    parameter int unsigned LEN_STEP     = 4,
    parameter int unsigned LEN_MIN      = 8,
    parameter int unsigned PAUSE_FRAMES = 60
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               launch_btn,
    input  logic               ball_lost,
    input  logic               bricks_clear,
    output logic [STATE_W-1:0] state,
    output logic               paddle_en,
    output logic [4:0]         paddle_len,
    output logic [1:0]         lives,
    output logic [2:0]         level,
    output logic               ball_reset,
    output logic               board_reload,
    output logic               game_over
);

    localparam logic [1:0] LIVES_INIT_L = 2'(LIVES_INIT);
    localparam logic [4:0] LEN_INIT_L   = 5'(LEN_INIT);
    localparam logic [4:0] LEN_STEP_L   = 5'(LEN_STEP);
    localparam logic [4:0] LEN_MIN_L    = 5'(LEN_MIN);
    localparam logic [7:0] PAUSE_L      = 8'(PAUSE_FRAMES);

    logic start_rise;
    logic launch_rise;

    btn_edge u_start_edge (
        .clock  (clock),
        .reset  (reset),
        .btn_i  (start_btn),
        .rise_o (start_rise)
    );

    btn_edge u_launch_edge (
        .clock  (clock),
        .reset  (reset),
        .btn_i  (launch_btn),
        .rise_o (launch_rise)
    );

    logic [STATE_W-1:0] state_q, state_d;
    logic [1:0]         lives_q, lives_d;
    logic [2:0]         level_q, level_d;
    logic [4:0]         len_q, len_d;
    logic [7:0]         timer_q, timer_d;
    logic               ball_reset_q, ball_reset_d;
    logic               board_reload_q, board_reload_d;

    logic [7:0] timer_inc;
    logic       pause_done;

    // The pause ends in the cycle of the PAUSE_FRAMES-th frame tick.
    assign timer_inc  = timer_q + 8'd1;
    assign pause_done = frame_tick && (timer_inc == PAUSE_L);

    always_comb begin
        state_d        = state_q;
        lives_d        = lives_q;
        level_d        = level_q;
        len_d          = len_q;
        timer_d        = timer_q;
        ball_reset_d   = 1'b0;
        board_reload_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_rise) begin
                    state_d        = ST_SERVE;
                    lives_d        = LIVES_INIT_L;
                    level_d        = 3'd0;
                    len_d          = LEN_INIT_L;
                    ball_reset_d   = 1'b1;
                    board_reload_d = 1'b1;
                end
            end

            ST_SERVE: begin
                if (launch_rise) begin
                    state_d = ST_PLAY;
                end
            end

            ST_PLAY: begin
                // A cleared board wins over a simultaneous lost ball.
                if (bricks_clear) begin
                    state_d = ST_LEVEL_CLEAR;
                    timer_d = 8'd0;
                    level_d = (level_q == LEVEL_MAX) ? level_q : level_q + 3'd1;
                    len_d   = shrink_len(len_q, LEN_STEP_L, LEN_MIN_L);
                end else if (ball_lost) begin
                    state_d = ST_LIFE_LOST;
                    timer_d = 8'd0;
                    if (lives_q != 2'd0) begin
                        lives_d = lives_q - 2'd1;
                    end
                end
            end

            ST_LIFE_LOST: begin
                if (frame_tick) begin
                    timer_d = timer_inc;
                end
                if (pause_done) begin
                    timer_d = 8'd0;
                    if (lives_q == 2'd0) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d      = ST_SERVE;
                        ball_reset_d = 1'b1;
                    end
                end
            end

            ST_LEVEL_CLEAR: begin
                if (frame_tick) begin
                    timer_d = timer_inc;
                end
                if (pause_done) begin
                    timer_d        = 8'd0;
                    state_d        = ST_SERVE;
                    ball_reset_d   = 1'b1;
                    board_reload_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            lives_q        <= 2'd0;
            level_q        <= 3'd0;
            len_q          <= LEN_INIT_L;
            timer_q        <= 8'd0;
            ball_reset_q   <= 1'b0;
            board_reload_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            level_q        <= level_d;
            len_q          <= len_d;
            timer_q        <= timer_d;
            ball_reset_q   <= ball_reset_d;
            board_reload_q <= board_reload_d;
        end
    end

    assign state        = state_q;
    assign paddle_en    = (state_q == ST_SERVE) || (state_q == ST_PLAY);
    assign paddle_len   = len_q;
    assign lives        = lives_q;
    assign level        = level_q;
    assign ball_reset   = ball_reset_q;
    assign board_reload = board_reload_q;
    assign game_over    = (state_q == ST_GAME_OVER);

endmodule
